ofs_plat_shim_ccip_mmio_rsp_arb: RTL and testbench
==================================================

Name: ofs_plat_shim_ccip_mmio_rsp_arb

Overview:
- Shares the single CCI-P c2 (MMIO read response) TX channel among NUM_SRC independent MMIO responders, such as sub-AFUs hanging off the MMIO half of a split host channel.
- Each source gets a one-entry holding register with a ready/valid handshake.
- A round-robin arbiter picks one held response per cycle and drives a registered c2 output.
- c2 has no flow control toward the FIU, so this block never stalls its output; backpressure exists only on the source side.

Parameters:
- NUM_SRC, 4, number of responder ports; legal range 1..16.
- TID_WIDTH, 9, MMIO transaction ID width (CCI-P tid).
- DATA_WIDTH, 64, MMIO read data width.

Ports:
- clk  in  1  block clock; all logic is in this single domain.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source response valid.
- src_tid  in  NUM_SRC*TID_WIDTH  per-source tid; source i occupies slice [i*TID_WIDTH +: TID_WIDTH].
- src_data  in  NUM_SRC*DATA_WIDTH  per-source read data, sliced the same way.
- src_ready  out  NUM_SRC  per-source accept.
- c2_mmioRdValid  out  1  response valid toward the FIU (c2 TX).
- c2_tid  out  TID_WIDTH  response tid.
- c2_data  out  DATA_WIDTH  response data.
- busy  out  1  high when any holding register is occupied or c2_mmioRdValid is high.

Behaviour:
- Reset (synchronous, active-high):
  - all hold_valid[i] = 0;
  - c2_mmioRdValid = 0; c2_tid and c2_data = 0;
  - last-grant pointer = NUM_SRC-1, so source 0 has first priority.
  - Reset asserted mid-operation discards held and in-flight responses. No partial output appears in the cycle after reset.
- Handshake: a transfer occurs on source i when src_valid[i] && src_ready[i] at a clk edge. src_ready[i] = !hold_valid[i] || grant[i]. It is combinational from registered state plus the arbiter and never depends on src_valid[i]. src_ready is 0 while reset is high.
- Holding register:
  - on a transfer, capture tid/data and set hold_valid[i];
  - on grant without a new transfer, clear hold_valid[i];
  - on grant with a simultaneous transfer, load the new entry and keep hold_valid[i] = 1. This gives full throughput of one response per cycle for a single streaming source.
- Arbiter: combinational round-robin over hold_valid. The search starts at (last+1) mod NUM_SRC. At most one grant per cycle. If any hold is valid there is exactly one grant. On a grant, last := granted index; with no grant, last is unchanged.
- Output register: on a grant, c2_mmioRdValid = 1 next cycle with the granted tid/data; otherwise c2_mmioRdValid = 0. c2_tid and c2_data keep their last value when valid is low, so verification checks them only when valid is high.
- Latency: accepted in cycle t, held in t+1, granted in t+1 at the earliest, visible on c2 in t+2. Worst-case wait for a held entry is NUM_SRC-1 cycles of other grants.
- Ordering:
  - per source, responses leave in acceptance order;
  - across sources, only round-robin fairness is guaranteed.
- Loss: the block never drops, duplicates or reorders a single source's responses. tid values pass through unchanged; no tid checking is done.
- NUM_SRC = 1: the arbiter degenerates to a grant whenever the hold is valid. Behaviour is otherwise identical.
- Bit widths: the pointer is $clog2(NUM_SRC) bits, with a minimum of 1. Wrap is the explicit mod NUM_SRC; non-power-of-two NUM_SRC must wrap at NUM_SRC-1 -> 0.

Decomposition:
- Shared package ofs_plat_ccip_mmio_rsp_pkg:
  - typedef t_mmio_rsp struct packed {tid, data}, sized by the package defaults;
  - localparam MMIO_RSP_MAX_SRC = 16.
- One sub-module: ofs_plat_prim_rr_arb (parameter NUM_REQ).
  - Inputs: clk, reset, request vector, enable.
  - Outputs: one-hot grant and grant index.
  - Owns the last-grant pointer and its reset value. It is reusable for the c0/c1 shims.

Test Plan:
- Reset then idle: after reset is held for 3 cycles, check c2_mmioRdValid = 0, src_ready = 4'b1111 and busy = 0 for 20 cycles.
- Single source: src 2 sends tid 0x011..0x018 (data = tid*0x1_0000_0001) back-to-back with valid held. Expect 8 consecutive c2 pulses, the first 2 cycles after the first accept, matching tid/data in order. src_ready[2] stays 1 throughout.
- All-source collision: all 4 sources present one response in the same cycle (tid 0x100+i). Expect c2 tids 0x100, 0x101, 0x102, 0x103 in 4 consecutive cycles. src_ready[3] is low for 3 cycles.
- Fairness wrap: sources 1 and 3 stream continuously for 40 cycles. Expect strict alternation 1, 3, 1, 3 and exactly 20 responses each.
- Reset mid-operation: load all 4 holds, assert reset for 1 cycle during the second grant. Expect no c2 valid in the cycle after reset and busy = 0. The next collision starts with source 0.
- NUM_SRC = 3 build: random valid traffic for 10k cycles with a scoreboard. Expect no loss or duplication, per-source order preserved, and every held entry granted within 2 cycles of other grants.

Source files
------------

// File: rtl/ofs_plat_ccip_mmio_rsp_pkg.sv
// Shared definitions for the CCI-P MMIO read-response shims.
//   t_mmio_rsp        : one MMIO read response (tid + data) at default widths
//   MMIO_RSP_MAX_SRC  : largest number of responders a shim may merge
//   rr_ptr_width()    : width of a round-robin pointer over n requesters
//                       (never less than one bit)
package ofs_plat_ccip_mmio_rsp_pkg;

  localparam int MMIO_RSP_MAX_SRC    = 16;
  localparam int MMIO_RSP_TID_WIDTH  = 9;
  localparam int MMIO_RSP_DATA_WIDTH = 64;

  typedef struct packed {
    logic [MMIO_RSP_TID_WIDTH-1:0]  tid;
    logic [MMIO_RSP_DATA_WIDTH-1:0] data;
  } t_mmio_rsp;

  function automatic int rr_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_rr_arb.sv
// Round-robin arbiter with an internal last-grant pointer.
//   clk, reset : clock and synchronous active-high reset
//   req        : request vector, one bit per requester
//   en         : when low no grant is issued and the pointer holds
//   grant      : one-hot grant (all zero when nothing is requested)
//   grant_idx  : binary index of the granted requester
// The search starts one past the last winner and wraps at NUM_REQ-1 -> 0,
// so non-power-of-two sizes never visit a nonexistent requester.
module ofs_plat_prim_rr_arb
  import ofs_plat_ccip_mmio_rsp_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic                              en,
  output logic [NUM_REQ-1:0]                grant,
  output logic [rr_ptr_width(NUM_REQ)-1:0]  grant_idx
);

  localparam int PTR_W = rr_ptr_width(NUM_REQ);

  logic [PTR_W-1:0] last_q, last_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    // Visit last+1 .. last+NUM_REQ (mod NUM_REQ); first requester wins.
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!found && en && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    last_d = found ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Pointing at the top requester gives requester 0 first priority.
      last_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ofs_plat_shim_ccip_mmio_rsp_arb.sv
// Merges NUM_SRC MMIO read-response streams onto the single CCI-P c2 channel.
//   clk, reset     : clock and synchronous active-high reset
//   src_valid/ready: per-source handshake; a response moves when both are
//                    high at a clock edge. src_ready[i] = !hold_valid[i] ||
//                    grant[i], never looks at src_valid, and is low in reset.
//   src_tid/data   : per-source payload, source i at [i*W +: W]
//   c2_mmioRdValid : registered response valid toward the FIU (no backpressure)
//   c2_tid/c2_data : registered response payload, held while valid is low
//   busy           : any holding register occupied or c2 valid high
// Each source owns a one-entry holding register; a round-robin arbiter moves
// one held entry per cycle into the c2 output register. A source granted in
// the same cycle it presents a new response reloads its holding register, so
// a lone streaming source sustains one response per cycle.
module ofs_plat_shim_ccip_mmio_rsp_arb
  import ofs_plat_ccip_mmio_rsp_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int TID_WIDTH  = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*TID_WIDTH-1:0]    src_tid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic                            c2_mmioRdValid,
  output logic [TID_WIDTH-1:0]            c2_tid,
  output logic [DATA_WIDTH-1:0]           c2_data,
  output logic                            busy
);

  localparam int PTR_W = rr_ptr_width(NUM_SRC);

  logic [NUM_SRC-1:0]    hold_valid_q, hold_valid_d;
  logic [TID_WIDTH-1:0]  hold_tid_q  [NUM_SRC];
  logic [TID_WIDTH-1:0]  hold_tid_d  [NUM_SRC];
  logic [DATA_WIDTH-1:0] hold_data_q [NUM_SRC];
  logic [DATA_WIDTH-1:0] hold_data_d [NUM_SRC];

  logic                  c2_valid_q, c2_valid_d;
  logic [TID_WIDTH-1:0]  c2_tid_q, c2_tid_d;
  logic [DATA_WIDTH-1:0] c2_data_q, c2_data_d;

  logic [NUM_SRC-1:0]    grant;
  logic [PTR_W-1:0]      grant_idx;
  logic [NUM_SRC-1:0]    xfer;
  logic                  arb_en;

  // Arbitration is suppressed in reset so nothing is committed to c2 from
  // state that is about to be discarded.
  assign arb_en = !reset;

  ofs_plat_prim_rr_arb #(
    .NUM_REQ (NUM_SRC)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (hold_valid_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    src_ready = reset ? '0 : (~hold_valid_q | grant);
    xfer      = src_valid & src_ready;
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_tid_d   = hold_tid_q;
    hold_data_d  = hold_data_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer[i]) begin
        // Covers both an empty slot and a reload alongside its own grant.
        hold_valid_d[i] = 1'b1;
        hold_tid_d[i]   = src_tid[i*TID_WIDTH +: TID_WIDTH];
        hold_data_d[i]  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end

    c2_valid_d = |grant;
    c2_tid_d   = c2_tid_q;
    c2_data_d  = c2_data_q;
    if (|grant) begin
      c2_tid_d  = hold_tid_q[grant_idx];
      c2_data_d = hold_data_q[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_tid_q[i]  <= '0;
        hold_data_q[i] <= '0;
      end
      c2_valid_q <= 1'b0;
      c2_tid_q   <= '0;
      c2_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_tid_q   <= hold_tid_d;
      hold_data_q  <= hold_data_d;
      c2_valid_q   <= c2_valid_d;
      c2_tid_q     <= c2_tid_d;
      c2_data_q    <= c2_data_d;
    end
  end

  assign c2_mmioRdValid = c2_valid_q;
  assign c2_tid         = c2_tid_q;
  assign c2_data        = c2_data_q;
  assign busy           = (|hold_valid_q) | c2_valid_q;

endmodule

// File: tb/tb_ofs_plat_shim_ccip_mmio_rsp_arb.sv
// Bench for the c2 MMIO response arbiter: a 4-source instance for directed
// scenarios and a 3-source instance for random traffic against a scoreboard.
module tb_ofs_plat_shim_ccip_mmio_rsp_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4-source DUT ----------------
  logic [3:0]   v4;
  logic [35:0]  t4;
  logic [255:0] dat4;
  logic [3:0]   r4;
  logic         c2v4;
  logic [8:0]   c2t4;
  logic [63:0]  c2d4;
  logic         busy4;

  ofs_plat_shim_ccip_mmio_rsp_arb #(.NUM_SRC(4), .TID_WIDTH(9), .DATA_WIDTH(64)) u_dut4 (
    .clk(clk), .reset(reset), .src_valid(v4), .src_tid(t4), .src_data(dat4),
    .src_ready(r4), .c2_mmioRdValid(c2v4), .c2_tid(c2t4), .c2_data(c2d4), .busy(busy4)
  );

  // ---------------- 3-source DUT ----------------
  logic [2:0]   v3;
  logic [26:0]  t3;
  logic [191:0] dat3;
  logic [2:0]   r3;
  logic         c2v3;
  logic [8:0]   c2t3;
  logic [63:0]  c2d3;
  logic         busy3;

  ofs_plat_shim_ccip_mmio_rsp_arb #(.NUM_SRC(3), .TID_WIDTH(9), .DATA_WIDTH(64)) u_dut3 (
    .clk(clk), .reset(reset), .src_valid(v3), .src_tid(t3), .src_data(dat3),
    .src_ready(r3), .c2_mmioRdValid(c2v3), .c2_tid(c2t3), .c2_data(c2d3), .busy(busy3)
  );

  // ---------------- scoreboard ----------------
  // Entry: {accept cycle[104:73], tid[72:64], data[63:0]}
  logic [104:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    v4 = '0;
    v3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (r4 !== 4'h0) begin n_fail++; $display("FAIL reset_ready_in_reset: got %h expected 0", r4); end
    n_checks++;
    if (c2v4 !== 1'b0) begin n_fail++; $display("FAIL reset_c2_valid: got %b expected 0", c2v4); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (c2v4 !== 1'b0) begin n_fail++; $display("FAIL idle_c2_valid: got %b expected 0", c2v4); end
      n_checks++;
      if (r4 !== 4'hf) begin n_fail++; $display("FAIL idle_ready: got %h expected f", r4); end
      n_checks++;
      if (busy4 !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy4); end
    end
  endtask

  task automatic test_single_source();
    int k, first_acc, n_out, idx;
    logic [8:0]  tv;
    logic [63:0] dv;
    logic        exp_v;
    k = 0; first_acc = -1; n_out = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (k < 8) begin
        tv = 9'h011 + 9'(k);
        v4[2] = 1'b1;
        t4[18 +: 9] = tv;
        dat4[128 +: 64] = {55'd0, tv} * 64'h0000_0001_0000_0001;
      end else begin
        v4[2] = 1'b0;
      end
      @(negedge clk);
      if (k < 8) begin
        n_checks++;
        if (r4[2] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", r4[2]); end
        if (v4[2] && r4[2]) begin
          if (k == 0) first_acc = cyc;
          k++;
        end
      end
      exp_v = (first_acc >= 0) && (cyc >= first_acc + 2) && (cyc < first_acc + 10);
      n_checks++;
      if (c2v4 !== exp_v) begin n_fail++; $display("FAIL single_c2_valid: got %b expected %b", c2v4, exp_v); end
      if (c2v4 && exp_v) begin
        idx = cyc - first_acc - 2;
        tv = 9'h011 + 9'(idx);
        dv = {55'd0, tv} * 64'h0000_0001_0000_0001;
        n_checks++;
        if (c2t4 !== tv) begin n_fail++; $display("FAIL single_tid: got %h expected %h", c2t4, tv); end
        n_checks++;
        if (c2d4 !== dv) begin n_fail++; $display("FAIL single_data: got %h expected %h", c2d4, dv); end
        n_out++;
      end
    end
    n_checks++;
    if (n_out != 8) begin n_fail++; $display("FAIL single_count: got %0d expected 8", n_out); end
  endtask

  task automatic test_collision(input logic [8:0] base);
    logic [63:0] ed [4];
    logic [3:0]  exp_r;
    logic [8:0]  tv;
    logic        exp_v;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ed[i] = {$urandom, $urandom};
      v4[i] = 1'b1;
      t4[i*9 +: 9] = base + 9'(i);
      dat4[i*64 +: 64] = ed[i];
    end
    @(negedge clk);
    n_checks++;
    if (r4 !== 4'hf) begin n_fail++; $display("FAIL coll_accept_ready: got %h expected f", r4); end
    @(posedge clk); #1;
    v4 = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      // Source i leaves its hold in cycle i+1 after acceptance.
      exp_r = (j <= 4) ? 4'((1 << j) - 1) : 4'hf;
      n_checks++;
      if (r4 !== exp_r) begin n_fail++; $display("FAIL coll_ready: got %h expected %h", r4, exp_r); end
      exp_v = (j >= 2) && (j <= 5);
      n_checks++;
      if (c2v4 !== exp_v) begin n_fail++; $display("FAIL coll_c2_valid: got %b expected %b", c2v4, exp_v); end
      if (exp_v && c2v4) begin
        tv = base + 9'(j - 2);
        n_checks++;
        if (c2t4 !== tv) begin n_fail++; $display("FAIL coll_tid: got %h expected %h", c2t4, tv); end
        n_checks++;
        if (c2d4 !== ed[j-2]) begin n_fail++; $display("FAIL coll_data: got %h expected %h", c2d4, ed[j-2]); end
      end
      if (j == 6) begin
        n_checks++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL coll_busy_end: got %b expected 0", busy4); end
      end
    end
  endtask

  task automatic test_fairness();
    int n1, n3, cnt1, cnt3, last_src, last_out, src;
    logic [6:0]  seq;
    logic [63:0] dv;
    n1 = 0; n3 = 0; cnt1 = 0; cnt3 = 0; last_src = -1; last_out = -1;
    v4 = '0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      v4[1] = (n1 < 20);
      t4[9 +: 9] = {2'd1, 7'(n1)};
      dat4[64 +: 64] = 64'(n1) * 64'h9E37_79B9_7F4A_7C15 ^ 64'd1;
      v4[3] = (n3 < 20);
      t4[27 +: 9] = {2'd3, 7'(n3)};
      dat4[192 +: 64] = 64'(n3) * 64'h9E37_79B9_7F4A_7C15 ^ 64'd3;
      @(negedge clk);
      if (c2v4) begin
        src = int'(c2t4[8:7]);
        seq = c2t4[6:0];
        if (src == 1) begin
          dv = 64'(cnt1) * 64'h9E37_79B9_7F4A_7C15 ^ 64'd1;
          n_checks++;
          if (seq !== 7'(cnt1) || c2d4 !== dv) begin
            n_fail++; $display("FAIL fair_src1_order: got %h/%h expected %h/%h", seq, c2d4, 7'(cnt1), dv);
          end
          cnt1++;
        end else if (src == 3) begin
          dv = 64'(cnt3) * 64'h9E37_79B9_7F4A_7C15 ^ 64'd3;
          n_checks++;
          if (seq !== 7'(cnt3) || c2d4 !== dv) begin
            n_fail++; $display("FAIL fair_src3_order: got %h/%h expected %h/%h", seq, c2d4, 7'(cnt3), dv);
          end
          cnt3++;
        end else begin
          n_checks++; n_fail++;
          $display("FAIL fair_src: got %0d expected 1 or 3", src);
        end
        if (last_src >= 0) begin
          n_checks++;
          if (src == last_src) begin n_fail++; $display("FAIL fair_alternate: got %0d twice expected alternation", src); end
          n_checks++;
          if (cyc != last_out + 1) begin n_fail++; $display("FAIL fair_gap: got cycle %0d expected %0d", cyc, last_out + 1); end
        end
        last_src = src;
        last_out = cyc;
      end
      if (v4[1] && r4[1]) n1++;
      if (v4[3] && r4[3]) n3++;
    end
    v4 = '0;
    n_checks++;
    if (cnt1 != 20) begin n_fail++; $display("FAIL fair_count1: got %0d expected 20", cnt1); end
    n_checks++;
    if (cnt3 != 20) begin n_fail++; $display("FAIL fair_count3: got %0d expected 20", cnt3); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      v4[i] = 1'b1;
      t4[i*9 +: 9] = 9'h200 + 9'(i);
      dat4[i*64 +: 64] = {$urandom, $urandom};
    end
    @(negedge clk);
    n_checks++;
    if (r4 !== 4'hf) begin n_fail++; $display("FAIL rmid_accept_ready: got %h expected f", r4); end
    @(posedge clk); #1;
    v4 = '0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (c2v4 !== 1'b1 || c2t4 !== 9'h200) begin
      n_fail++; $display("FAIL rmid_first_grant: got %b/%h expected 1/200", c2v4, c2t4);
    end
    n_checks++;
    if (r4 !== 4'h0) begin n_fail++; $display("FAIL rmid_ready_in_reset: got %h expected 0", r4); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (c2v4 !== 1'b0) begin n_fail++; $display("FAIL rmid_c2_after_reset: got %b expected 0", c2v4); end
    n_checks++;
    if (busy4 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy4); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (c2v4 !== 1'b0) begin n_fail++; $display("FAIL rmid_c2_idle: got %b expected 0", c2v4); end
    end
    test_collision(9'h300);
  endtask

  task automatic test_random_3src(input int n_cycles);
    logic [6:0]   seq [3];
    logic [2:0]   acc;
    logic         exp_busy;
    logic [104:0] e;
    int           fk, lat;
    for (int i = 0; i < 3; i++) seq[i] = '0;
    acc = '0;
    v3 = '0;
    exp_q.delete();
    for (int c = 0; c < n_cycles + 12; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (!v3[i] || acc[i]) begin
          if (c < n_cycles && $urandom_range(0, 99) < 60) begin
            v3[i] = 1'b1;
            t3[i*9 +: 9] = {2'(i), seq[i]};
            dat3[i*64 +: 64] = {$urandom, $urandom};
            seq[i] = seq[i] + 7'd1;
          end else begin
            v3[i] = 1'b0;
          end
        end
      end
      @(negedge clk);
      // Anything accepted at an earlier edge and not yet seen on c2 is inside.
      exp_busy = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (int'(exp_q[k][104:73]) < cyc) exp_busy = 1'b1;
      end
      n_checks++;
      if (busy3 !== exp_busy) begin n_fail++; $display("FAIL rand_busy: got %b expected %b", busy3, exp_busy); end
      if (c2v3) begin
        fk = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (fk < 0 && exp_q[k][72:71] == c2t3[8:7]) fk = k;
        end
        n_checks++;
        if (fk < 0) begin
          n_fail++; $display("FAIL rand_unexpected: got tid %h expected nothing pending", c2t3);
        end else begin
          e = exp_q[fk];
          lat = cyc - int'(e[104:73]);
          if (c2t3 !== e[72:64] || c2d3 !== e[63:0]) begin
            n_fail++; $display("FAIL rand_payload: got %h/%h expected %h/%h", c2t3, c2d3, e[72:64], e[63:0]);
          end
          n_checks++;
          if (lat < 2 || lat > 4) begin n_fail++; $display("FAIL rand_latency: got %0d expected 2..4", lat); end
          exp_q.delete(fk);
        end
      end
      acc = v3 & r3;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) exp_q.push_back({32'(cyc), t3[i*9 +: 9], dat3[i*64 +: 64]});
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    v4 = '0; t4 = '0; dat4 = '0;
    v3 = '0; t3 = '0; dat3 = '0;
    test_reset();
    test_single_source();
    test_reset();
    test_collision(9'h100);
    test_fairness();
    test_reset_mid();
    test_random_3src(10000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
